mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port memory between the pipeline's instruction-fetch stage and its data-memory stage. It accepts one request at a time, issues it to the memory with a valid/ready handshake, and waits for the memory response. It then returns the response to the requester that owns the transaction. Data accesses have priority, and a starvation counter guarantees fetch progress.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive contended data grants before fetch is forced (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge)
- if_req  in  1  fetch request (read only)
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  data response valid (read data or write completion)
- d_rdata  out  DATA_W  read data; 0 for writes
- m_req  out  1  memory request valid
- m_we, m_addr, m_wdata  out  1/ADDR_W/DATA_W  memory command, stable while m_req=1
- m_ready  in  1  memory accepts command when m_req&&m_ready
- m_rvalid  in  1  memory response (reads and writes)
- m_rdata  in  DATA_W  memory read data

## Operation
- FSM with three states: IDLE, ISSUE, WAIT.
- IDLE:
  - With any request pending, arbitrate combinationally and pulse the winner's ack in the same cycle.
  - Latch owner, we, addr and wdata (fetch: we=0, wdata=0).
  - Go to ISSUE.
- ISSUE: m_req=1 with the latched command. On m_ready=1, go to WAIT.
- WAIT: on m_rvalid=1, go to IDLE. Register m_rdata to the owner's rdata and pulse the owner's rvalid next cycle (d_rdata=0 when owner wrote).
- Arbitration:
  - Data wins by default.
  - Fetch wins if only if_req is asserted, or if both are asserted and starve_cnt==STARVE_MAX.
- starve_cnt, width $clog2(STARVE_MAX+1), saturates at STARVE_MAX:
  - +1 on a data grant while if_req=1.
  - Cleared on a fetch grant.
  - Cleared on a data grant while if_req=0.
- Requesters hold req/addr/data stable until ack; the arbiter does not re-sample them after ack.
- m_rvalid is honored only in WAIT; in IDLE/ISSUE it is ignored (no rvalid pulse, no state change).
- Exactly one outstanding memory transaction; no ack is issued outside IDLE.

## Timing
- Reset (reset==0 at an edge):
  - state=IDLE, starve_cnt=0, owner=fetch.
  - All outputs 0: acks, rvalids, rdatas, m_req, m_we, m_addr, m_wdata.
- Reset mid-transaction: aborted; no rvalid is produced for it; a late m_rvalid is ignored.
- Sequence for a request accepted at cycle T:
  - ack at T, m_req from T+1.
  - m_ready at T+k (k≥1) means WAIT from T+k+1.
  - m_rvalid at cycle R means owner rvalid at R+1.
  - State is IDLE at R+1, so the next ack can occur at R+1.
- Minimum round trip (m_ready at T+1, m_rvalid at T+2): rvalid at T+3; back-to-back accepts every 3 cycles.
- m_req, m_we, m_addr, m_wdata are registered and remain constant through ISSUE until the handshake; m_req=0 in IDLE and WAIT.
- ack is combinational from IDLE and the requests; rvalid/rdata are registered.

## Test plan
- Single fetch:
  - Stimulus: if_req, if_addr=0x0 at T; m_ready=1 at T+1; m_rvalid=1 with m_rdata=0xDEADBEEF at T+2.
  - Response: if_ack at T; m_req=1, m_addr=0 at T+1; if_rvalid=1, if_rdata=0xDEADBEEF at T+3; d_* stays 0.
- Data write with backpressure:
  - Stimulus: d_req, d_we=1, d_addr=0x4, d_wdata=0x12345678; m_ready held 0 for 3 cycles.
  - Response: m_req=1 with m_we=1, m_addr=0x4, m_wdata=0x12345678 stable for 4 cycles, ending at the handshake; d_rvalid=1 with d_rdata=0 one cycle after m_rvalid.
- Contention (STARVE_MAX=4): if_req and d_req held high continuously, memory latency 1 → grant order D,D,D,D,I,D,D,D,D,I.
- Only-fetch then data: fetch granted, d_req raised while in WAIT → no d_ack until IDLE; d_ack in the same cycle as if_rvalid.
- Reset during WAIT: reset=0 for one edge, then m_rvalid=1 → no if_rvalid/d_rvalid; all outputs 0; next request is accepted normally.
- Stray response: m_rvalid=1 with m_rdata=0xFEDCBA98 while IDLE → no rvalid pulse, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data access
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ready,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t            r_state;
   logic [SW-1:0]     r_starve;
   logic              r_owner_d;
   logic              r_m_req;
   logic              r_m_we;
   logic [ADDR_W-1:0] r_m_addr;
   logic [DATA_W-1:0] r_m_wdata;
   logic              r_if_rvalid;
   logic [DATA_W-1:0] r_if_rdata;
   logic              r_d_rvalid;
   logic [DATA_W-1:0] r_d_rdata;

   logic w_idle;
   logic w_force_if;
   logic w_grant_d;
   logic w_grant_i;

   // Data wins by default; fetch wins when alone or when it has been starved long enough.
   assign w_idle     = (r_state == S_IDLE);
   assign w_force_if = if_req && (r_starve == STARVE_LIM);
   assign w_grant_d  = w_idle && d_req && !w_force_if;
   assign w_grant_i  = w_idle && if_req && !w_grant_d;

   assign if_ack    = w_grant_i;
   assign d_ack     = w_grant_d;
   assign if_rvalid = r_if_rvalid;
   assign if_rdata  = r_if_rdata;
   assign d_rvalid  = r_d_rvalid;
   assign d_rdata   = r_d_rdata;
   assign m_req     = r_m_req;
   assign m_we      = r_m_we;
   assign m_addr    = r_m_addr;
   assign m_wdata   = r_m_wdata;

   // Transaction FSM: latch the winner's command, hold it until the memory takes it, route the response back.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_starve    <= '0;
         r_owner_d   <= 1'b0;
         r_m_req     <= 1'b0;
         r_m_we      <= 1'b0;
         r_m_addr    <= '0;
         r_m_wdata   <= '0;
         r_if_rvalid <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rvalid  <= 1'b0;
         r_d_rdata   <= '0;
      end else begin
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_d) begin
                  r_owner_d <= 1'b1;
                  r_m_we    <= d_we;
                  r_m_addr  <= d_addr;
                  r_m_wdata <= d_wdata;
                  r_m_req   <= 1'b1;
                  r_state   <= S_ISSUE;
                  // Only grants that actually beat a waiting fetch count toward starvation.
                  if (if_req) begin
                     if (r_starve != STARVE_LIM) begin
                        r_starve <= r_starve + STARVE_ONE;
                     end
                  end else begin
                     r_starve <= '0;
                  end
               end else if (w_grant_i) begin
                  r_owner_d <= 1'b0;
                  r_m_we    <= 1'b0;
                  r_m_addr  <= if_addr;
                  r_m_wdata <= '0;
                  r_m_req   <= 1'b1;
                  r_state   <= S_ISSUE;
                  r_starve  <= '0;
               end
            end
            S_ISSUE: begin
               if (m_ready) begin
                  r_m_req <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (m_rvalid) begin
                  r_state <= S_IDLE;
                  if (r_owner_d) begin
                     r_d_rvalid <= 1'b1;
                     r_d_rdata  <= r_m_we ? '0 : m_rdata;
                  end else begin
                     r_if_rvalid <= 1'b1;
                     r_if_rdata  <= m_rdata;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_m_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_ready;
   logic              m_rvalid;
   logic [DATA_W-1:0] m_rdata;

   int n_checks = 0;
   int n_errors = 0;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ireq;
      logic        dreq;
      logic        dwe;
      logic [31:0] iaddr;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      int          ready_dly;
      logic [31:0] mem_rdata;
      logic        exp_if_ack;
      logic        exp_d_ack;
      logic        exp_mwe;
      logic [31:0] exp_maddr;
      logic [31:0] exp_mwdata;
      logic [31:0] exp_rdata;
   } row_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      m_ready = 0; m_rvalid = 0; m_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 0;
      tick();
      tick();
      reset = 1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_ack"}, if_ack, 0);
      chk({tag, "_d_ack"}, d_ack, 0);
      chk({tag, "_if_rvalid"}, if_rvalid, 0);
      chk({tag, "_d_rvalid"}, d_rvalid, 0);
      chk({tag, "_if_rdata"}, if_rdata, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
      chk({tag, "_m_req"}, m_req, 0);
      chk({tag, "_m_we"}, m_we, 0);
      chk({tag, "_m_addr"}, m_addr, 0);
      chk({tag, "_m_wdata"}, m_wdata, 0);
   endtask

   row_t rows[6];

   // Random-phase reference model state
   logic        pend_i, pend_d, r_dwe;
   logic [31:0] r_ia, r_da, r_dwd;
   int          stage;
   int          starve;
   logic        c_owner_d, c_we;
   logic [31:0] c_addr, c_wdata;
   logic        e_irv, e_drv;
   logic [31:0] e_irdata, e_drdata;
   logic        g_d, g_i;

   logic exp_order[10];
   logic got_order[$];

   initial begin
      reset = 1;
      idle_inputs();

      rows[0] = '{1, 0, 0, 32'h0,   32'h0,   32'h0,        1, 32'hDEADBEEF, 1, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF};
      rows[1] = '{0, 1, 1, 32'h0,   32'h4,   32'h12345678, 4, 32'h55AA55AA, 0, 1, 1, 32'h4,   32'h12345678, 32'h0};
      rows[2] = '{0, 1, 0, 32'h0,   32'h100, 32'hABCD0001, 2, 32'hCAFEF00D, 0, 1, 0, 32'h100, 32'hABCD0001, 32'hCAFEF00D};
      rows[3] = '{1, 1, 0, 32'h200, 32'h300, 32'h0,        1, 32'h0BADF00D, 0, 1, 0, 32'h300, 32'h0,        32'h0BADF00D};
      rows[4] = '{1, 1, 1, 32'h204, 32'h304, 32'h77,       2, 32'h11111111, 0, 1, 1, 32'h304, 32'h77,       32'h0};
      rows[5] = '{1, 0, 0, 32'h208, 32'h0,   32'h0,        3, 32'h13579BDF, 1, 0, 0, 32'h208, 32'h0,        32'h13579BDF};

      // Reset state
      do_reset();
      @(negedge clk);
      chk_all_zero("reset");

      // Table-driven single transactions
      for (int r = 0; r < 6; r++) begin
         tick();
         if_req = rows[r].ireq; if_addr = rows[r].iaddr;
         d_req = rows[r].dreq; d_we = rows[r].dwe; d_addr = rows[r].daddr; d_wdata = rows[r].dwdata;
         m_ready = 0; m_rvalid = 0;
         @(negedge clk);
         chk($sformatf("row%0d_if_ack", r), if_ack, rows[r].exp_if_ack);
         chk($sformatf("row%0d_d_ack", r), d_ack, rows[r].exp_d_ack);
         chk($sformatf("row%0d_m_req_idle", r), m_req, 0);
         tick();
         if_req = 0; d_req = 0;
         for (int k = 1; k <= rows[r].ready_dly; k++) begin
            m_ready = (k == rows[r].ready_dly);
            @(negedge clk);
            chk($sformatf("row%0d_m_req_c%0d", r, k), m_req, 1);
            chk($sformatf("row%0d_m_we_c%0d", r, k), m_we, rows[r].exp_mwe);
            chk($sformatf("row%0d_m_addr_c%0d", r, k), m_addr, rows[r].exp_maddr);
            chk($sformatf("row%0d_m_wdata_c%0d", r, k), m_wdata, rows[r].exp_mwdata);
            tick();
         end
         m_ready = 0; m_rvalid = 1; m_rdata = rows[r].mem_rdata;
         @(negedge clk);
         chk($sformatf("row%0d_m_req_wait", r), m_req, 0);
         chk($sformatf("row%0d_no_early_rv", r), {if_rvalid, d_rvalid}, 0);
         tick();
         m_rvalid = 0;
         @(negedge clk);
         chk($sformatf("row%0d_if_rvalid", r), if_rvalid, rows[r].exp_if_ack);
         chk($sformatf("row%0d_d_rvalid", r), d_rvalid, rows[r].exp_d_ack);
         if (rows[r].exp_if_ack) chk($sformatf("row%0d_if_rdata", r), if_rdata, rows[r].exp_rdata);
         else                    chk($sformatf("row%0d_d_rdata", r), d_rdata, rows[r].exp_rdata);
      end

      // Stray response while idle: ignored, arbiter stays idle
      tick();
      idle_inputs();
      m_rvalid = 1; m_rdata = 32'hFEDCBA98;
      tick();
      m_rvalid = 0;
      if_req = 1; if_addr = 32'h44;
      @(negedge clk);
      chk("stray_if_rvalid", if_rvalid, 0);
      chk("stray_d_rvalid", d_rvalid, 0);
      chk("stray_still_idle_ack", if_ack, 1);
      tick();
      if_req = 0; m_ready = 1;
      tick();
      m_ready = 0; m_rvalid = 1; m_rdata = 32'h0000CAFE;
      tick();
      m_rvalid = 0;
      @(negedge clk);
      chk("stray_followup_rdata", if_rdata, 32'h0000CAFE);

      // Only fetch, then data raised during WAIT
      tick();
      if_req = 1; if_addr = 32'h60;
      @(negedge clk);
      chk("of_if_ack", if_ack, 1);
      tick();
      if_req = 0; m_ready = 1;
      tick();
      m_ready = 0; d_req = 1; d_we = 0; d_addr = 32'h40; d_wdata = 0;
      @(negedge clk);
      chk("of_no_dack_wait0", d_ack, 0);
      tick();
      m_rvalid = 1; m_rdata = 32'h11112222;
      @(negedge clk);
      chk("of_no_dack_wait1", d_ack, 0);
      tick();
      m_rvalid = 0;
      @(negedge clk);
      chk("of_if_rvalid", if_rvalid, 1);
      chk("of_if_rdata", if_rdata, 32'h11112222);
      chk("of_d_ack_same_cycle", d_ack, 1);
      tick();
      d_req = 0; m_ready = 1;
      @(negedge clk);
      chk("of_m_addr", m_addr, 32'h40);
      tick();
      m_ready = 0; m_rvalid = 1; m_rdata = 32'h33334444;
      tick();
      m_rvalid = 0;
      @(negedge clk);
      chk("of_d_rvalid", d_rvalid, 1);
      chk("of_d_rdata", d_rdata, 32'h33334444);

      // Reset during WAIT
      tick();
      idle_inputs();
      if_req = 1; if_addr = 32'h80;
      @(negedge clk);
      chk("rw_if_ack", if_ack, 1);
      tick();
      if_req = 0; m_ready = 1;
      tick();
      m_ready = 0; reset = 0;
      tick();
      reset = 1; m_rvalid = 1; m_rdata = 32'h99999999;
      @(negedge clk);
      chk_all_zero("rw_after_reset");
      tick();
      m_rvalid = 0;
      d_req = 1; d_we = 1; d_addr = 32'hC; d_wdata = 32'hA5A5A5A5;
      @(negedge clk);
      chk("rw_no_if_rvalid", if_rvalid, 0);
      chk("rw_no_d_rvalid", d_rvalid, 0);
      chk("rw_m_req", m_req, 0);
      chk("rw_next_d_ack", d_ack, 1);
      tick();
      d_req = 0; m_ready = 1;
      @(negedge clk);
      chk("rw_next_m_we", m_we, 1);
      chk("rw_next_m_addr", m_addr, 32'hC);
      tick();
      m_ready = 0; m_rvalid = 1; m_rdata = 32'h12121212;
      tick();
      m_rvalid = 0;
      @(negedge clk);
      chk("rw_next_d_rvalid", d_rvalid, 1);
      chk("rw_next_d_rdata", d_rdata, 0);

      // Contention with latency 1: expect D,D,D,D,I,D,D,D,D,I
      do_reset();
      for (int i = 0; i < 10; i++) exp_order[i] = ((i % (STARVE_MAX + 1)) != STARVE_MAX);
      got_order.delete();
      if_req = 1; if_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000;
      m_ready = 1; m_rvalid = 1; m_rdata = 32'h5;
      for (int c = 0; c < 60 && got_order.size() < 10; c++) begin
         @(negedge clk);
         if (if_ack && d_ack) chk("cont_double_ack", 1, 0);
         if (d_ack) got_order.push_back(1'b1);
         else if (if_ack) got_order.push_back(1'b0);
         tick();
      end
      chk("cont_grant_count", got_order.size(), 10);
      for (int i = 0; i < got_order.size() && i < 10; i++)
         chk($sformatf("cont_grant%0d_is_data", i), got_order[i], exp_order[i]);
      if_req = 0; d_req = 0;
      for (int c = 0; c < 4; c++) tick();
      idle_inputs();

      // Randomized traffic against reference model
      do_reset();
      pend_i = 0; pend_d = 0; stage = 0; starve = 0;
      e_irv = 0; e_drv = 0; e_irdata = 0; e_drdata = 0;
      r_ia = 0; r_da = 0; r_dwd = 0; r_dwe = 0;
      c_owner_d = 0; c_we = 0; c_addr = 0; c_wdata = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         if (!pend_i && $urandom_range(0, 2) == 0) begin pend_i = 1; r_ia = $urandom; end
         if (!pend_d && $urandom_range(0, 2) == 0) begin
            pend_d = 1; r_dwe = 1'($urandom_range(0, 1)); r_da = $urandom; r_dwd = $urandom;
         end
         if_req = pend_i; if_addr = r_ia;
         d_req = pend_d; d_we = r_dwe; d_addr = r_da; d_wdata = r_dwd;
         m_ready = 1'($urandom_range(0, 1));
         m_rdata = $urandom;
         m_rvalid = (stage == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         g_d = 0; g_i = 0;
         if (stage == 0) begin
            if (pend_i && pend_d) begin
               if (starve >= STARVE_MAX) g_i = 1; else g_d = 1;
            end else if (pend_d) g_d = 1;
            else if (pend_i) g_i = 1;
         end
         @(negedge clk);
         chk("rnd_if_ack", if_ack, g_i);
         chk("rnd_d_ack", d_ack, g_d);
         chk("rnd_m_req", m_req, stage == 1);
         if (stage == 1) begin
            chk("rnd_m_we", m_we, c_we);
            chk("rnd_m_addr", m_addr, c_addr);
            chk("rnd_m_wdata", m_wdata, c_wdata);
         end
         chk("rnd_if_rvalid", if_rvalid, e_irv);
         chk("rnd_d_rvalid", d_rvalid, e_drv);
         if (e_irv) chk("rnd_if_rdata", if_rdata, e_irdata);
         if (e_drv) chk("rnd_d_rdata", d_rdata, e_drdata);
         e_irv = 0; e_drv = 0;
         if (g_d) begin
            starve = pend_i ? ((starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1) : 0;
            c_owner_d = 1; c_we = r_dwe; c_addr = r_da; c_wdata = r_dwd;
            pend_d = 0; stage = 1;
         end else if (g_i) begin
            starve = 0;
            c_owner_d = 0; c_we = 0; c_addr = r_ia; c_wdata = 0;
            pend_i = 0; stage = 1;
         end else if (stage == 1 && m_ready) begin
            stage = 2;
         end else if (stage == 2 && m_rvalid) begin
            stage = 0;
            if (c_owner_d) begin e_drv = 1; e_drdata = c_we ? 32'h0 : m_rdata; end
            else begin e_irv = 1; e_irdata = m_rdata; end
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
